// File: rtl/alu_issue_arbiter_pkg.sv
// alu_issue_arbiter_pkg: ALU command encodings and NZCV bit positions shared by the ALU issue path.
package alu_issue_arbiter_pkg;
    localparam logic [3:0] CMD_MOV = 4'd0;
    localparam logic [3:0] CMD_MVN = 4'd1;
    localparam logic [3:0] CMD_ADD = 4'd2;
    localparam logic [3:0] CMD_ADC = 4'd3;
    localparam logic [3:0] CMD_SUB = 4'd4;
    localparam logic [3:0] CMD_SBC = 4'd5;
    localparam logic [3:0] CMD_AND = 4'd6;
    localparam logic [3:0] CMD_ORR = 4'd7;
    localparam logic [3:0] CMD_EOR = 4'd8;
    localparam logic [3:0] CMD_CMP = 4'd9;
    localparam logic [3:0] CMD_TST = 4'd10;
    localparam logic [3:0] CMD_LDR = 4'd11;
    localparam logic [3:0] CMD_STR = 4'd12;
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;
endpackage

// File: rtl/alu_issue_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; on a tie the requester that did not win last time gets it.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       update_i,
    output logic       grant_o,
    output logic       any_o
);
    logic rr_last_q;
    assign grant_o = &valid_i ? ~rr_last_q : valid_i[1];
    assign any_o   = |valid_i;
    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_last_q <= 1'b1;
        else if (update_i)
            rr_last_q <= grant_o;
    end
endmodule

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: serializes two requesters onto one combinational ALU, returns tagged results
// over valid/ready and owns the architectural NZCV register.
module alu_issue_arbiter
    import alu_issue_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CMD_W-1:0]  req0_cmd,
    input  logic [DATA_W-1:0] req0_val1,
    input  logic [DATA_W-1:0] req0_val2,
    input  logic              req0_s,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CMD_W-1:0]  req1_cmd,
    input  logic [DATA_W-1:0] req1_val1,
    input  logic [DATA_W-1:0] req1_val2,
    input  logic              req1_s,
    output logic [CMD_W-1:0]  alu_cmd,
    output logic [DATA_W-1:0] alu_val1,
    output logic [DATA_W-1:0] alu_val2,
    output logic              alu_c_in,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    output logic [3:0]        resp_nzcv,
    output logic [3:0]        status_nzcv
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
    state_e            state_q, state_d;
    logic              gnt, any_valid, accept;
    logic [CMD_W-1:0]  cmd_q;
    logic [DATA_W-1:0] val1_q, val2_q, data_q;
    logic              s_q, id_q;
    logic [3:0]        nzcv_q, status_q;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  ({req1_valid, req0_valid}),
        .update_i (accept),
        .grant_o  (gnt),
        .any_o    (any_valid)
    );

    // rst_n gates the handshake so readies read 0 while reset is held.
    assign accept = rst_n & (state_q == IDLE) & ~flush & any_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = flush             ? IDLE :
                  state_q == IDLE   ? (accept ? EXEC : IDLE) :
                  state_q == EXEC   ? RESP :
                  resp_ready        ? IDLE : RESP;
    end

    always_comb begin
        req0_ready = accept & ~gnt;
        req1_ready = accept & gnt;
        resp_valid = state_q == RESP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q    <= '0;
            val1_q   <= '0;
            val2_q   <= '0;
            s_q      <= 1'b0;
            id_q     <= 1'b0;
            data_q   <= '0;
            nzcv_q   <= '0;
            status_q <= '0;
        end else begin
            if (accept) begin
                cmd_q  <= gnt ? req1_cmd  : req0_cmd;
                val1_q <= gnt ? req1_val1 : req0_val1;
                val2_q <= gnt ? req1_val2 : req0_val2;
                s_q    <= gnt ? req1_s    : req0_s;
                id_q   <= gnt;
            end
            // A flushed op never reaches the result or status registers.
            if (state_q == EXEC && !flush) begin
                data_q <= alu_out;
                nzcv_q <= {alu_n, alu_z, alu_c, alu_v};
                if (s_q)
                    status_q <= {alu_n, alu_z, alu_c, alu_v};
            end
        end
    end

    assign alu_cmd     = cmd_q;
    assign alu_val1    = val1_q;
    assign alu_val2    = val2_q;
    assign alu_c_in    = status_q[NZCV_C];
    assign resp_id     = id_q;
    assign resp_data   = data_q;
    assign resp_nzcv   = nzcv_q;
    assign status_nzcv = status_q;
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed vector table plus hand sequences for contention, backpressure,
// flush and mid-op reset; a small ALU model stands in for the real ALU.
module tb_alu_issue_arbiter;
    import alu_issue_arbiter_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic        req0_valid = 1'b0, req0_ready, req0_s = 1'b0;
    logic [3:0]  req0_cmd = '0;
    logic [31:0] req0_val1 = '0, req0_val2 = '0;
    logic        req1_valid = 1'b0, req1_ready, req1_s = 1'b0;
    logic [3:0]  req1_cmd = '0;
    logic [31:0] req1_val1 = '0, req1_val2 = '0;
    logic [3:0]  alu_cmd;
    logic [31:0] alu_val1, alu_val2, alu_out;
    logic        alu_c_in, alu_n, alu_z, alu_c, alu_v;
    logic        resp_valid, resp_ready = 1'b0, resp_id;
    logic [31:0] resp_data;
    logic [3:0]  resp_nzcv, status_nzcv;

    int checks = 0, errors = 0;

    alu_issue_arbiter #(.DATA_W(32), .CMD_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
        .req0_val1(req0_val1), .req0_val2(req0_val2), .req0_s(req0_s),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
        .req1_val1(req1_val1), .req1_val2(req1_val2), .req1_s(req1_s),
        .alu_cmd(alu_cmd), .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_c_in(alu_c_in),
        .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_nzcv(resp_nzcv), .status_nzcv(status_nzcv)
    );

    always #5 clk = ~clk;

    // Reference ALU: ADD/ADC/SUB with ARM-style flags; anything else passes val1 through.
    logic [32:0] sum;
    always_comb begin
        sum   = {1'b0, alu_val1};
        alu_v = 1'b0;
        case (alu_cmd)
            CMD_ADD: begin
                sum   = {1'b0, alu_val1} + {1'b0, alu_val2};
                alu_v = (alu_val1[31] == alu_val2[31]) && (sum[31] != alu_val1[31]);
            end
            CMD_ADC: begin
                sum   = {1'b0, alu_val1} + {1'b0, alu_val2} + {32'd0, alu_c_in};
                alu_v = (alu_val1[31] == alu_val2[31]) && (sum[31] != alu_val1[31]);
            end
            CMD_SUB: begin
                sum   = {1'b0, alu_val1} + {1'b0, ~alu_val2} + 33'd1;
                alu_v = (alu_val1[31] != alu_val2[31]) && (sum[31] != alu_val1[31]);
            end
            default: sum = {1'b0, alu_val1};
        endcase
    end
    assign alu_out = sum[31:0];
    assign alu_n   = sum[31];
    assign alu_z   = sum[31:0] == 32'd0;
    assign alu_c   = (alu_cmd == CMD_ADD || alu_cmd == CMD_ADC || alu_cmd == CMD_SUB) ? sum[32] : 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Presents one op and lets it be accepted; returns #1 after the accepting edge.
    task automatic issue(input bit rid, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input bit s);
        @(negedge clk);
        if (rid) begin
            req1_valid = 1'b1; req1_cmd = cmd; req1_val1 = a; req1_val2 = b; req1_s = s;
        end else begin
            req0_valid = 1'b1; req0_cmd = cmd; req0_val1 = a; req0_val2 = b; req0_s = s;
        end
        #1 chk("issue_ready", {30'd0, req1_ready, req0_ready}, rid ? 32'd2 : 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    typedef struct {
        bit          rid;
        logic [3:0]  cmd;
        logic [31:0] a, b;
        bit          s;
        bit          exp_cin;
        logic [31:0] exp_data;
        logic [3:0]  exp_nzcv, exp_status;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, CMD_ADD, 32'h5,        32'h3, 1'b1, 1'b0, 32'h8,        4'b0000, 4'b0000};
        vecs[1] = '{1'b1, CMD_ADD, 32'hFFFFFFFF, 32'h1, 1'b1, 1'b0, 32'h0,        4'b0110, 4'b0110};
        vecs[2] = '{1'b0, CMD_ADC, 32'h1,        32'h1, 1'b0, 1'b1, 32'h3,        4'b0000, 4'b0110};
        vecs[3] = '{1'b1, CMD_SUB, 32'h2,        32'h5, 1'b0, 1'b1, 32'hFFFFFFFD, 4'b1000, 4'b0110};
        vecs[4] = '{1'b0, CMD_SUB, 32'h2,        32'h5, 1'b1, 1'b1, 32'hFFFFFFFD, 4'b1000, 4'b1000};
        vecs[5] = '{1'b1, CMD_ADD, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b0, 32'h80000000, 4'b1001, 4'b1001};
        vecs[6] = '{1'b0, CMD_ADC, 32'h1,        32'h1, 1'b1, 1'b0, 32'h2,        4'b0000, 4'b0000};
        vecs[7] = '{1'b1, 4'hF,    32'h1234,     32'h9, 1'b0, 1'b0, 32'h1234,     4'b0000, 4'b0000};

        // Reset state, with both valids high to show readies are held low.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_nzcv", {28'd0, resp_nzcv}, 32'd0);
        chk("rst_status", {28'd0, status_nzcv}, 32'd0);
        chk("rst_alu_cmd", {28'd0, alu_cmd}, 32'd0);
        chk("rst_alu_val1", alu_val1, 32'd0);
        chk("rst_alu_val2", alu_val2, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].rid, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].s);
            @(negedge clk);
            chk("exec_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("exec_c_in", {31'd0, alu_c_in}, {31'd0, vecs[i].exp_cin});
            @(negedge clk);
            chk("resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("resp_id", {31'd0, resp_id}, {31'd0, vecs[i].rid});
            chk("resp_data", resp_data, vecs[i].exp_data);
            chk("resp_nzcv", {28'd0, resp_nzcv}, {28'd0, vecs[i].exp_nzcv});
            chk("status", {28'd0, status_nzcv}, {28'd0, vecs[i].exp_status});
            resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = 1'b0;
        end

        // Contention: grants alternate 0,1,0,1 with one accept every 3 cycles.
        @(negedge clk);
        req0_cmd = CMD_MOV; req0_s = 1'b0; req1_cmd = CMD_MOV; req1_s = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1 chk("contention_ready", {30'd0, req1_ready, req0_ready},
                   (c % 3 != 0) ? 32'd0 : ((c / 3) % 2 == 1) ? 32'd2 : 32'd1);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;

        // Backpressure: response held stable for 5 cycles, no grants meanwhile.
        issue(1'b0, CMD_ADD, 32'h1, 32'h2, 1'b0);
        req1_valid = 1'b1;
        @(negedge clk);
        chk("bp_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_resp_data", resp_data, 32'd3);
            chk("bp_resp_id", {31'd0, resp_id}, 32'd0);
            chk("bp_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("bp_release_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp_next_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
        req1_valid = 1'b0;

        // Flush in IDLE suppresses the grant.
        @(negedge clk);
        req0_valid = 1'b1; flush = 1'b1;
        #1 chk("flush_idle_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        flush = 1'b0;
        #1 chk("unflush_idle_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        req0_valid = 1'b0;

        // Flush in EXEC of a flag-setting op: no response, status untouched.
        issue(1'b0, CMD_ADD, 32'hFFFFFFFF, 32'h1, 1'b1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("flush_exec_valid", {31'd0, resp_valid}, 32'd0);
            chk("flush_exec_status", {28'd0, status_nzcv}, 32'd0);
        end

        // Flush together with resp_ready in RESP drops the response.
        issue(1'b1, CMD_MOV, 32'h55, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("flush_resp_pre", {31'd0, resp_valid}, 32'd1);
        chk("flush_resp_data", resp_data, 32'h55);
        flush = 1'b1; resp_ready = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; resp_ready = 1'b0;
        chk("flush_resp_valid", {31'd0, resp_valid}, 32'd0);

        // Asynchronous reset in RESP clears everything immediately.
        issue(1'b0, CMD_ADD, 32'hFFFFFFFF, 32'h1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("prerst_status", {28'd0, status_nzcv}, 32'h6);
        chk("prerst_valid", {31'd0, resp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, resp_valid}, 32'd0);
        chk("arst_status", {28'd0, status_nzcv}, 32'd0);
        chk("arst_resp_nzcv", {28'd0, resp_nzcv}, 32'd0);
        chk("arst_alu_val1", alu_val1, 32'd0);
        chk("arst_alu_cmd", {28'd0, alu_cmd}, 32'd0);
        chk("arst_c_in", {31'd0, alu_c_in}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares the single combinational ALU between two requesters: req0 is the execute stage and req1 is the multi-cycle/auxiliary unit.
- Arbitrates round-robin and registers the selected command and operands into the ALU.
- Captures the ALU result and flags, then returns them with a requester ID over a valid/ready response.
- Owns the architectural NZCV status register and drives the ALU carry-in from it.

Parameters:
DATA_W, 32, operand/result width
CMD_W, 4, ALU command width (matches ALU command encoding)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of in-flight op
req0_valid  in  1  requester 0 has op
req0_ready  out  1  requester 0 op accepted this cycle
req0_cmd  in  CMD_W  ALU command
req0_val1  in  DATA_W  operand 1
req0_val2  in  DATA_W  operand 2
req0_s  in  1  update status on completion
req1_valid/req1_ready/req1_cmd/req1_val1/req1_val2/req1_s  as req0, requester 1
alu_cmd  out  CMD_W  to ALU
alu_val1  out  DATA_W  to ALU
alu_val2  out  DATA_W  to ALU
alu_c_in  out  1  to ALU, = status C
alu_out  in  DATA_W  ALU result
alu_n/alu_z/alu_c/alu_v  in  1 each  ALU flags
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts
resp_id  out  1  requester that issued op
resp_data  out  DATA_W  captured result
resp_nzcv  out  4  captured flags {N,Z,C,V}
status_nzcv  out  4  architectural status register

Behaviour:
- Reset (async, rst_n low): state IDLE; rr_last=1, so req0 wins the first tie. All of the following are 0: status_nzcv, resp_valid, resp_id, resp_data, resp_nzcv, alu_cmd, alu_val1, alu_val2, both readies.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant rule:
  - Only one valid: grant that requester.
  - Both valid: grant the requester != rr_last.
  - reqN_ready = (state==IDLE) & grant==N & !flush. It is combinational from the valids; at most one ready is high.
- IDLE, handshake (valid&ready, cycle T): latch cmd/val1/val2/s/id into the operand registers (these drive alu_*). Set rr_last=id and go to EXEC.
- EXEC (cycle T+1): the ALU evaluates the registered operands.
  - At the clock edge, capture alu_out and flags into resp_data/resp_nzcv.
  - If latched s=1, status_nzcv <= {alu_n,alu_z,alu_c,alu_v} at the same edge.
  - Go to RESP.
- RESP (T+2 onward): resp_valid=1. resp_id/resp_data/resp_nzcv stay stable until resp_ready.
  - On resp_valid&resp_ready, go to IDLE.
  - The earliest next acceptance is the following cycle, giving a minimum of 3 cycles per op.
- alu_c_in = status_nzcv[1] (C), registered value.
  - An op issued after a flag-setting op sees the updated carry, because ops are fully serialized.
- Results are passed through unchanged. The block does not decode commands or inspect flags; unknown commands return whatever the ALU produces.
- flush (sync, highest priority):
  - In IDLE: no grant this cycle.
  - In EXEC: drop the op. No capture and no status update. Go to IDLE.
  - In RESP: drop resp_valid. Go to IDLE.
  - status_nzcv is never altered by flush.
- Simultaneous flush & resp_ready in RESP: treat as flush. The response is counted as dropped.
- A requester must hold valid/operands stable until ready. Withdrawal before ready is allowed and is not an error.
- rst_n asserted mid-op returns to reset values immediately; no response is produced.

Decomposition:
- Shared package: ALU command constants (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR, CMP, TST, LDR, STR) and the NZCV bit-index constants N=3, Z=2, C=1, V=0.
- FSM state encoding stays local.
- One natural sub-module: rr_arbiter2 (2-way round-robin grant with rr_last register).
- The ALU itself is instantiated at the top level beside this block, not inside it.

Test Plan:
- Single op: req0 ADD(0x0000_0005,0x0000_0003), s=1. Required: req0_ready in cycle T; resp_valid at T+2; resp_data=0x8, resp_id=0, status_nzcv updated to ALU flags.
- Contention: both valid every cycle, resp_ready=1. Required: grants alternate 0,1,0,1 starting with 0; one accept every 3 cycles.
- Carry chain:
  - req1 ADD(0xFFFF_FFFF,0x1), s=1, with an ALU that drives C=1 on this carry.
  - Then ADC(0x1,0x1).
  - Required: alu_c_in=1 during the second EXEC; resp_data=0x3.
- s=0: SUB(0x2,0x5). Required: resp_data=0xFFFF_FFFD; status_nzcv unchanged from its prior value.
- Backpressure: resp_ready=0 for 5 cycles. Required: resp_* stable; no readies asserted. Release → IDLE and the next grant on the following cycle.
- Flush in EXEC (s=1). Required: no resp_valid, status_nzcv unchanged. Also rst_n pulse in RESP: all outputs 0 asynchronously.
